// File: rtl/invaders_pkg.sv
// invaders_pkg: shared geometry, widths and FSM encoding for the invaders
// collision logic.
//   NUM_ROWS/NUM_COLS : alien formation size
//   ALIEN_W/ALIEN_H   : alien box size in pixels
//   LASER_W/LASER_H   : laser box size in pixels
//   POS_W             : width of one packed alien coordinate
//   hit_state_t       : hit_detector FSM states
package invaders_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 5;
  localparam int ALIEN_W  = 16;
  localparam int ALIEN_H  = 8;
  localparam int LASER_W  = 2;
  localparam int LASER_H  = 8;
  localparam int POINTS   = 10;
  localparam int SCORE_W  = 12;
  localparam int POS_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RELOAD = 2'd2
  } hit_state_t;

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational axis-aligned rectangle intersection test.
//   a_x/a_y : top-left of box A (A_W x A_H)
//   b_x/b_y : top-left of box B (B_W x B_H)
//   hit     : 1 when the two boxes share at least one pixel
// Comparisons are done one bit wider than the coordinates so that adding a
// box size to a coordinate near the top of the range cannot wrap.
module box_overlap
  import invaders_pkg::*;
#(
  parameter int A_W = LASER_W,
  parameter int A_H = LASER_H,
  parameter int B_W = ALIEN_W,
  parameter int B_H = ALIEN_H
) (
  input  logic [POS_W-1:0] a_x,
  input  logic [POS_W-1:0] a_y,
  input  logic [POS_W-1:0] b_x,
  input  logic [POS_W-1:0] b_y,
  output logic             hit
);

  localparam logic [POS_W:0] AW = (POS_W+1)'(A_W);
  localparam logic [POS_W:0] AH = (POS_W+1)'(A_H);
  localparam logic [POS_W:0] BW = (POS_W+1)'(B_W);
  localparam logic [POS_W:0] BH = (POS_W+1)'(B_H);

  logic [POS_W:0] ax, ay, bx, by;

  assign ax = {1'b0, a_x};
  assign ay = {1'b0, a_y};
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};

  assign hit = (ax < bx + BW) && (ax + AW > bx) &&
               (ay < by + BH) && (ay + AH > by);

endmodule

// File: rtl/hit_detector.sv
// hit_detector: per-frame laser/alien collision scan and kill bookkeeping.
// Owns the alive matrix consumed by alien_formation.
//   clk, reset       : clock, synchronous active-high reset
//   vsync            : frame sync; rising edge starts a frame
//   laser_active     : laser in flight
//   laser_x/laser_y  : laser top-left
//   alien_pos_x/y    : packed alien top-left coords, alien i at [16i +: 16]
//   alive_matrix     : bit i = alien i alive
//   hit_alien        : one-cycle kill pulse
//   kill_row/col     : position of last kill (held)
//   wave_clear       : one-cycle pulse with the kill of the last alien
//   score            : saturating score
// Build option: define HIT_SCORE_EN to include the score counter; without it
// score is tied to zero.
//
// state  | meaning
// IDLE   | waiting for a frame edge
// SCAN   | comparing alien idx against the laser, one alien per clock
// RELOAD | wave was cleared; restore all aliens, no scan this frame
module hit_detector
  import invaders_pkg::*;
#(
  parameter int NUM_ROWS = invaders_pkg::NUM_ROWS,
  parameter int NUM_COLS = invaders_pkg::NUM_COLS,
  parameter int ALIEN_W  = invaders_pkg::ALIEN_W,
  parameter int ALIEN_H  = invaders_pkg::ALIEN_H,
  parameter int LASER_W  = invaders_pkg::LASER_W,
  parameter int LASER_H  = invaders_pkg::LASER_H,
  parameter int POINTS   = invaders_pkg::POINTS,
  parameter int SCORE_W  = invaders_pkg::SCORE_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               vsync,
  input  logic                               laser_active,
  input  logic [9:0]                         laser_x,
  input  logic [9:0]                         laser_y,
  input  logic [POS_W*NUM_ROWS*NUM_COLS-1:0] alien_pos_x,
  input  logic [POS_W*NUM_ROWS*NUM_COLS-1:0] alien_pos_y,
  output logic [NUM_ROWS*NUM_COLS-1:0]       alive_matrix,
  output logic                               hit_alien,
  output logic [$clog2(NUM_ROWS)-1:0]        kill_row,
  output logic [$clog2(NUM_COLS)-1:0]        kill_col,
  output logic                               wave_clear,
  output logic [SCORE_W-1:0]                 score
);

  localparam int N     = NUM_ROWS * NUM_COLS;
  localparam int IDX_W = $clog2(N);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] COLS_I   = IDX_W'(NUM_COLS);

  hit_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     alive_q, alive_d;
  logic             hit_q, hit_d;
  logic             wave_q, wave_d;
  logic [ROW_W-1:0] kill_row_q, kill_row_d;
  logic [COL_W-1:0] kill_col_q, kill_col_d;
  logic             vsync_q;

  logic             frame_edge;
  logic [POS_W-1:0] cur_x, cur_y;
  logic             box_hit;
  logic             overlap;
  logic [N-1:0]     alive_after_kill;

  assign frame_edge = vsync && !vsync_q;

  assign cur_x = alien_pos_x[POS_W*idx_q +: POS_W];
  assign cur_y = alien_pos_y[POS_W*idx_q +: POS_W];

  box_overlap #(
    .A_W(LASER_W),
    .A_H(LASER_H),
    .B_W(ALIEN_W),
    .B_H(ALIEN_H)
  ) u_box_overlap (
    .a_x({{(POS_W-10){1'b0}}, laser_x}),
    .a_y({{(POS_W-10){1'b0}}, laser_y}),
    .b_x(cur_x),
    .b_y(cur_y),
    .hit(box_hit)
  );

  assign overlap          = alive_q[idx_q] && box_hit;
  assign alive_after_kill = alive_q & ~(N'(1) << idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    alive_d    = alive_q;
    hit_d      = 1'b0;
    wave_d     = 1'b0;
    kill_row_d = kill_row_q;
    kill_col_d = kill_col_q;
    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          if (alive_q == '0) begin
            state_d = RELOAD;
          end else if (laser_active) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
      end
      SCAN: begin
        if (overlap) begin
          state_d    = IDLE;
          hit_d      = 1'b1;
          alive_d    = alive_after_kill;
          wave_d     = (alive_after_kill == '0);
          kill_row_d = ROW_W'(idx_q / COLS_I);
          kill_col_d = COL_W'(idx_q % COLS_I);
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RELOAD: begin
        alive_d = '1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      alive_q    <= '1;
      hit_q      <= 1'b0;
      wave_q     <= 1'b0;
      kill_row_q <= '0;
      kill_col_q <= '0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      alive_q    <= alive_d;
      hit_q      <= hit_d;
      wave_q     <= wave_d;
      kill_row_q <= kill_row_d;
      kill_col_q <= kill_col_d;
      vsync_q    <= vsync;
    end
  end

`ifdef HIT_SCORE_EN
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;

  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS);

  always_comb begin
    score_d = score_q;
    if (state_q == SCAN && overlap) begin
      // saturate instead of wrapping
      score_d = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                        : score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

  assign alive_matrix = alive_q;
  assign hit_alien    = hit_q;
  assign wave_clear   = wave_q;
  assign kill_row     = kill_row_q;
  assign kill_col     = kill_col_q;

endmodule
